// File: rtl/huff_pkg.sv
// huff_pkg: shared state encoding, default sizes and width helper for the Huffman code-table builder
package huff_pkg;

    typedef enum logic [1:0] {IDLE, BUILD, DONE} hcb_state_t;

    localparam int NSYM_DEF = 6;
    localparam int CW_DEF   = 8;

    function automatic int lw_of(input int cw);
        return $clog2(cw + 1);
    endfunction

endpackage

// File: rtl/huff_sym_slot.sv
// huff_sym_slot: one symbol's codeword, valid-bit mask and length accumulator
//   i_clk   rising-edge clock
//   i_reset synchronous active-low reset
//   i_clr   clear code, mask and len
//   i_upd   append i_bit at position len
//   i_bit   bit value to append
//   o_code  accumulated codeword, first bit at position 0
//   o_mask  set bits mark valid code positions
//   o_len   number of bits appended, saturating at CW
module huff_sym_slot
    import huff_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int LW = lw_of(CW)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clr,
    input  logic          i_upd,
    input  logic          i_bit,
    output logic [CW-1:0] o_code,
    output logic [CW-1:0] o_mask,
    output logic [LW-1:0] o_len
);

    logic [CW-1:0] r_code;
    logic [CW-1:0] r_mask;
    logic [LW-1:0] r_len;
    logic [CW-1:0] w_pos;
    logic          w_room;

    // one-hot write position; an update at len==CW is dropped so the slot saturates
    assign w_pos  = CW'(1) << r_len;
    assign w_room = r_len < LW'(CW);

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clr) begin
            r_code <= '0;
            r_mask <= '0;
            r_len  <= '0;
        end else if (i_upd && w_room) begin
            r_code <= i_bit ? (r_code | w_pos) : (r_code & ~w_pos);
            r_mask <= r_mask | w_pos;
            r_len  <= r_len + 1'b1;
        end
    end

    assign o_code = r_code;
    assign o_mask = r_mask;
    assign o_len  = r_len;

endmodule

// File: rtl/huff_code_builder.sv
// huff_code_builder: accumulates per-symbol Huffman codes from a stream of subtree combines
//   i_clk        rising-edge clock
//   i_reset      synchronous active-low reset
//   i_start      clear tables and begin a build (beats a same-cycle combine)
//   i_cmb_valid  combine request valid
//   o_cmb_ready  combine accept, combinational from state and i_start
//   i_grp0       lighter subtree members, receive bit 1
//   i_grp1       heavier subtree members, receive bit 0
//   i_cmb_last   root combine, ends the build
//   o_code       packed codewords, symbol i at [i*CW +: CW]
//   o_mask       packed valid-bit masks
//   o_len        packed code lengths, symbol i at [i*LW +: LW]
//   o_done       table complete
//   o_err        sticky illegal-combine / overflow flag
// Option HCB_OVF_CHECK_EN: suppress and flag any combine touching a full-length symbol.
module huff_code_builder
    import huff_pkg::*;
#(
    parameter int NSYM = NSYM_DEF,
    parameter int CW   = CW_DEF,
    parameter int LW   = lw_of(CW)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_cmb_valid,
    output logic               o_cmb_ready,
    input  logic [NSYM-1:0]    i_grp0,
    input  logic [NSYM-1:0]    i_grp1,
    input  logic               i_cmb_last,
    output logic [NSYM*CW-1:0] o_code,
    output logic [NSYM*CW-1:0] o_mask,
    output logic [NSYM*LW-1:0] o_len,
    output logic               o_done,
    output logic               o_err
);

    hcb_state_t      r_state;
    hcb_state_t      w_next;
    logic            r_done;
    logic            r_err;
    logic            w_accept;
    logic            w_illegal;
    logic            w_ovf;
    logic            w_upd_en;
    logic [NSYM-1:0] w_sel;

    assign o_cmb_ready = (r_state == BUILD) && !i_start;
    assign w_accept    = i_cmb_valid && o_cmb_ready;
    assign w_sel       = i_grp0 | i_grp1;
    assign w_illegal   = (|(i_grp0 & i_grp1)) || !(|i_grp0) || !(|i_grp1);

`ifdef HCB_OVF_CHECK_EN
    logic [NSYM-1:0] w_full;
    assign w_ovf = |(w_sel & w_full);
`else
    assign w_ovf = 1'b0;
`endif

    // an illegal or overflowing combine is still consumed, but writes nothing
    assign w_upd_en = w_accept && !w_illegal && !w_ovf;

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_start)
            w_next = BUILD;
        else if (w_accept && i_cmb_last)
            w_next = DONE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_next == DONE;
            r_err  <= i_start ? 1'b0 : (r_err | (w_accept && (w_illegal || w_ovf)));
        end
    end

    assign o_done = r_done;
    assign o_err  = r_err;

    for (genvar g = 0; g < NSYM; g++) begin : g_slot
        huff_sym_slot #(.CW(CW), .LW(LW)) u_slot (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_clr   (i_start),
            .i_upd   (w_upd_en && w_sel[g]),
            .i_bit   (i_grp0[g]),
            .o_code  (o_code[g*CW +: CW]),
            .o_mask  (o_mask[g*CW +: CW]),
            .o_len   (o_len[g*LW +: LW])
        );
`ifdef HCB_OVF_CHECK_EN
        assign w_full[g] = o_len[g*LW +: LW] == LW'(CW);
`endif
    end

endmodule

// File: tb/tb_huff_code_builder.sv
// tb_huff_code_builder: randomized self-checking bench against a behavioural code-table model
module tb_huff_code_builder;

    localparam int NSYM = 6;
    localparam int CW   = 8;
    localparam int LW   = $clog2(CW + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               cmb_valid = 1'b0;
    logic               cmb_last = 1'b0;
    logic [NSYM-1:0]    grp0 = '0;
    logic [NSYM-1:0]    grp1 = '0;
    logic               cmb_ready;
    logic [NSYM*CW-1:0] code;
    logic [NSYM*CW-1:0] mask;
    logic [NSYM*LW-1:0] len;
    logic               done;
    logic               err;

    huff_code_builder #(.NSYM(NSYM), .CW(CW), .LW(LW)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_cmb_valid (cmb_valid),
        .o_cmb_ready (cmb_ready),
        .i_grp0      (grp0),
        .i_grp1      (grp1),
        .i_cmb_last  (cmb_last),
        .o_code      (code),
        .o_mask      (mask),
        .o_len       (len),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [CW-1:0] m_code [NSYM];
    logic [CW-1:0] m_mask [NSYM];
    logic [LW-1:0] m_len  [NSYM];
    int            m_state;
    logic          m_err;
    logic          m_done;
    logic          rdy;
    logic          erdy;

    task automatic model_clear();
        for (int i = 0; i < NSYM; i++) begin
            m_code[i] = '0;
            m_mask[i] = '0;
            m_len[i]  = '0;
        end
    endtask

    task automatic model_combine(input logic [NSYM-1:0] g0, input logic [NSYM-1:0] g1, input logic last);
`ifdef HCB_OVF_CHECK_EN
        logic ovf = 1'b0;
`endif
        if ((g0 & g1) != 0 || g0 == 0 || g1 == 0) begin
            m_err = 1'b1;
        end else begin
`ifdef HCB_OVF_CHECK_EN
            for (int i = 0; i < NSYM; i++)
                if ((g0[i] || g1[i]) && m_len[i] == LW'(CW)) ovf = 1'b1;
            if (ovf) m_err = 1'b1; else
`endif
            for (int i = 0; i < NSYM; i++) begin
                if ((g0[i] || g1[i]) && m_len[i] < LW'(CW)) begin
                    m_code[i] = g0[i] ? (m_code[i] | (CW'(1) << m_len[i])) : (m_code[i] & ~(CW'(1) << m_len[i]));
                    m_mask[i] = m_mask[i] | (CW'(1) << m_len[i]);
                    m_len[i]  = m_len[i] + 1'b1;
                end
            end
        end
        if (last) m_state = 2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        m_state = 0;
        m_err   = 1'b0;
        m_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    // called at a falling edge; returns with outputs settled at the next falling edge
    task automatic cycle(input logic st, input logic v, input logic [NSYM-1:0] g0, input logic [NSYM-1:0] g1, input logic l);
        start = st; cmb_valid = v; grp0 = g0; grp1 = g1; cmb_last = l;
        erdy = (m_state == 1) && !st;
        #1 rdy = cmb_ready;
        if (st) begin
            model_clear();
            m_err = 1'b0;
            m_state = 1;
        end else if (v && m_state == 1) begin
            model_combine(g0, g1, l);
        end
        m_done = m_state == 2;
        @(posedge clk);
        #1 start = 1'b0; cmb_valid = 1'b0; cmb_last = 1'b0; grp0 = '0; grp1 = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 3;
        if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
        if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
        if (cmb_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b exp 0", cmb_ready); end
        for (int i = 0; i < NSYM; i++) begin
            n_cmp++;
            if ({code[i*CW +: CW], mask[i*CW +: CW], len[i*LW +: LW]} !== '0) begin
                n_bad++; $display("FAIL reset_tbl sym%0d got %h/%h/%0d exp 0", i, code[i*CW +: CW], mask[i*CW +: CW], len[i*LW +: LW]);
            end
        end
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        n_cmp += 3;
        if (cmb_ready !== 1'b1) begin n_bad++; $display("FAIL start_ready got %b exp 1", cmb_ready); end
        if (done !== 1'b0) begin n_bad++; $display("FAIL start_done got %b exp 0", done); end
        if (code !== '0 || mask !== '0 || len !== '0) begin n_bad++; $display("FAIL start_tbl got %h %h %h exp 0", code, mask, len); end
    endtask

    task automatic test_basic();
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b1, 6'b000001, 6'b000010, 1'b0);
        cycle(1'b0, 1'b1, 6'b000100, 6'b000011, 1'b0);
        n_cmp += 7;
        if (code[0 +: CW] !== 8'b01) begin n_bad++; $display("FAIL basic_code0 got %b exp 00000001", code[0 +: CW]); end
        if (len[0 +: LW] !== 4'd2) begin n_bad++; $display("FAIL basic_len0 got %0d exp 2", len[0 +: LW]); end
        if (code[CW +: CW] !== 8'b00) begin n_bad++; $display("FAIL basic_code1 got %b exp 0", code[CW +: CW]); end
        if (len[LW +: LW] !== 4'd2) begin n_bad++; $display("FAIL basic_len1 got %0d exp 2", len[LW +: LW]); end
        if (code[2*CW +: CW] !== 8'b1) begin n_bad++; $display("FAIL basic_code2 got %b exp 1", code[2*CW +: CW]); end
        if (len[2*LW +: LW] !== 4'd1) begin n_bad++; $display("FAIL basic_len2 got %0d exp 1", len[2*LW +: LW]); end
        if (mask[0 +: CW] !== 8'b11) begin n_bad++; $display("FAIL basic_mask0 got %b exp 11", mask[0 +: CW]); end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            logic [NSYM-1:0] q[$];
            logic [NSYM-1:0] g0, g1;
            int a, b, sum_exp, sum_got;
            cycle(1'b1, 1'b0, '0, '0, 1'b0);
            q.delete();
            for (int i = 0; i < NSYM; i++) q.push_back(NSYM'(1) << i);
            sum_exp = 0;
            for (int k = 0; k < NSYM - 1; k++) begin
                a = $urandom_range(q.size() - 1);
                b = (a + 1 + $urandom_range(q.size() - 2)) % q.size();
                g0 = q[a];
                g1 = q[b];
                if (a > b) begin q.delete(a); q.delete(b); end else begin q.delete(b); q.delete(a); end
                q.push_back(g0 | g1);
                sum_exp += $countones(g0 | g1);
                cycle(1'b0, 1'b1, g0, g1, k == NSYM - 2);
                n_cmp++;
                if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_ready r%0d k%0d got %b exp 1", r, k, rdy); end
            end
            sum_got = 0;
            for (int i = 0; i < NSYM; i++) sum_got += int'(len[i*LW +: LW]);
            n_cmp += 3;
            if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done r%0d got %b exp 1", r, done); end
            if (sum_got != sum_exp) begin n_bad++; $display("FAIL b2b_lensum r%0d got %0d exp %0d", r, sum_got, sum_exp); end
            if (err !== 1'b0) begin n_bad++; $display("FAIL b2b_err r%0d got %b exp 0", r, err); end
            for (int i = 0; i < NSYM; i++) begin
                n_cmp++;
                if ({code[i*CW +: CW], mask[i*CW +: CW], len[i*LW +: LW]} !== {m_code[i], m_mask[i], m_len[i]}) begin
                    n_bad++; $display("FAIL b2b_tbl sym%0d got %h/%h/%0d exp %h/%h/%0d", i, code[i*CW +: CW], mask[i*CW +: CW], len[i*LW +: LW], m_code[i], m_mask[i], m_len[i]);
                end
            end
            cycle(1'b0, 1'b1, 6'b000001, 6'b000010, 1'b0);
            n_cmp += 3;
            if (rdy !== 1'b0) begin n_bad++; $display("FAIL done_ready got %b exp 0", rdy); end
            if (done !== 1'b1) begin n_bad++; $display("FAIL done_hold got %b exp 1", done); end
            if (len[0 +: LW] !== m_len[0]) begin n_bad++; $display("FAIL done_tbl got %0d exp %0d", len[0 +: LW], m_len[0]); end
        end
    endtask

    task automatic test_illegal();
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b1, 6'b000001, 6'b000010, 1'b0);
        cycle(1'b0, 1'b1, 6'b000011, 6'b000010, 1'b0);
        n_cmp += 3;
        if (err !== 1'b1) begin n_bad++; $display("FAIL overlap_err got %b exp 1", err); end
        if (len[0 +: LW] !== 4'd1 || len[LW +: LW] !== 4'd1) begin n_bad++; $display("FAIL overlap_len got %0d,%0d exp 1,1", len[0 +: LW], len[LW +: LW]); end
        if (code[0 +: CW] !== 8'b1) begin n_bad++; $display("FAIL overlap_code0 got %b exp 1", code[0 +: CW]); end
        cycle(1'b0, 1'b1, 6'b000000, 6'b000100, 1'b0);
        cycle(1'b0, 1'b1, 6'b000100, 6'b001000, 1'b0);
        n_cmp += 3;
        if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_sticky got %b exp 1", err); end
        if (len[2*LW +: LW] !== 4'd1 || code[2*CW +: CW] !== 8'b1) begin n_bad++; $display("FAIL illegal_after sym2 got %b/%0d exp 1/1", code[2*CW +: CW], len[2*LW +: LW]); end
        if (len[3*LW +: LW] !== 4'd1 || mask[3*CW +: CW] !== 8'b1) begin n_bad++; $display("FAIL illegal_after sym3 got %b/%0d exp 1/1", mask[3*CW +: CW], len[3*LW +: LW]); end
        cycle(1'b0, 1'b1, 6'b010000, 6'b010000, 1'b1);
        n_cmp += 2;
        if (done !== 1'b1) begin n_bad++; $display("FAIL illegal_last_done got %b exp 1", done); end
        if (len[4*LW +: LW] !== 4'd0) begin n_bad++; $display("FAIL illegal_last_tbl got %0d exp 0", len[4*LW +: LW]); end
    endtask

    task automatic test_start_priority();
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b1, 6'b110000, 6'b001111, 1'b0);
        cycle(1'b0, 1'b1, 6'b000000, 6'b000001, 1'b0);
        cycle(1'b1, 1'b1, 6'b000001, 6'b000010, 1'b0);
        n_cmp += 3;
        if (rdy !== 1'b0) begin n_bad++; $display("FAIL prio_ready got %b exp 0", rdy); end
        if (code !== '0 || mask !== '0 || len !== '0) begin n_bad++; $display("FAIL prio_tbl got %h %h %h exp 0", code, mask, len); end
        if (err !== 1'b0) begin n_bad++; $display("FAIL prio_err got %b exp 0", err); end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        repeat (CW) cycle(1'b0, 1'b1, 6'b000001, 6'b000010, 1'b0);
        n_cmp += 2;
        if (len[0 +: LW] !== LW'(CW)) begin n_bad++; $display("FAIL ovf_fill_len got %0d exp %0d", len[0 +: LW], CW); end
        if (err !== 1'b0) begin n_bad++; $display("FAIL ovf_fill_err got %b exp 0", err); end
        cycle(1'b0, 1'b1, 6'b000001, 6'b000110, 1'b0);
        n_cmp += 4;
        if (len[0 +: LW] !== LW'(CW)) begin n_bad++; $display("FAIL ovf_len got %0d exp %0d", len[0 +: LW], CW); end
        if (code[0 +: CW] !== 8'hFF || mask[0 +: CW] !== 8'hFF) begin n_bad++; $display("FAIL ovf_code got %h/%h exp ff/ff", code[0 +: CW], mask[0 +: CW]); end
`ifdef HCB_OVF_CHECK_EN
        if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_err got %b exp 1", err); end
        if (len[2*LW +: LW] !== 4'd0) begin n_bad++; $display("FAIL ovf_suppress got %0d exp 0", len[2*LW +: LW]); end
`else
        if (err !== 1'b0) begin n_bad++; $display("FAIL ovf_err got %b exp 0", err); end
        if (len[2*LW +: LW] !== 4'd1) begin n_bad++; $display("FAIL ovf_partner got %0d exp 1", len[2*LW +: LW]); end
`endif
    endtask

    task automatic test_random();
        logic [NSYM-1:0] g0, g1;
        logic st, v, l;
        cycle(1'b1, 1'b0, '0, '0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(59) == 0) begin
                cycle(1'b0, 1'b1, 6'b000001, 6'b000010, 1'b0);
                do_reset();
            end else begin
                st = $urandom_range(19) == 0;
                v  = $urandom_range(3) != 0;
                l  = $urandom_range(15) == 0;
                g0 = NSYM'($urandom);
                g1 = ($urandom_range(4) == 0) ? NSYM'($urandom) : (NSYM'($urandom) & ~g0);
                cycle(st, v, g0, g1, l);
                n_cmp++;
                if (rdy !== erdy) begin n_bad++; $display("FAIL rnd_ready c%0d got %b exp %b", c, rdy, erdy); end
            end
            n_cmp += 2;
            if (done !== m_done) begin n_bad++; $display("FAIL rnd_done c%0d got %b exp %b", c, done, m_done); end
            if (err !== m_err) begin n_bad++; $display("FAIL rnd_err c%0d got %b exp %b", c, err, m_err); end
            for (int i = 0; i < NSYM; i++) begin
                n_cmp++;
                if ({code[i*CW +: CW], mask[i*CW +: CW], len[i*LW +: LW]} !== {m_code[i], m_mask[i], m_len[i]}) begin
                    n_bad++; $display("FAIL rnd_tbl c%0d sym%0d got %h/%h/%0d exp %h/%h/%0d", c, i, code[i*CW +: CW], mask[i*CW +: CW], len[i*LW +: LW], m_code[i], m_mask[i], m_len[i]);
                end
            end
            if (m_state != 1 && $urandom_range(2) == 0) cycle(1'b1, 1'b0, '0, '0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_start_priority();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
